// File: rtl/rl_fifo_1r1w_pkg.sv
// Shared constants for the FWFT FIFO.
//   BUF_DEPTH : entries in the output prefetch buffer
//   fifo_cap  : total word capacity for a given RAM address width
package rl_fifo_1r1w_pkg;

   localparam int BUF_DEPTH = 2;

   function automatic int fifo_cap(input int abits);
      return (32'sd1 <<< abits) + BUF_DEPTH;
   endfunction

endpackage

// File: rtl/rl_ram_1r1w.sv
// Simple dual-port RAM: one write port and one registered read port.
// Read data appears one cycle after re_i. A same-address read/write in
// the same cycle returns the newly written (byte-merged) word.
//   clk_i    clock
//   rst_ni   synchronous active-low reset (clears dout_o only)
//   we_i     write enable
//   waddr_i  write address
//   din_i    write data
//   be_i     byte enables, one per 8 data bits
//   re_i     read enable
//   raddr_i  read address
//   dout_o   read data, 1-cycle latency, held between reads
module rl_ram_1r1w #(
   parameter int    ABITS      = 10,
   parameter int    DBITS      = 32,
   parameter string TECHNOLOGY = "GENERIC",
   localparam int   BW         = (DBITS + 7) / 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             we_i,
   input  logic [ABITS-1:0] waddr_i,
   input  logic [DBITS-1:0] din_i,
   input  logic [BW-1:0]    be_i,
   input  logic             re_i,
   input  logic [ABITS-1:0] raddr_i,
   output logic [DBITS-1:0] dout_o
);

   logic [DBITS-1:0] mem [2**ABITS];
   logic [DBITS-1:0] wmask;
   logic [DBITS-1:0] wdata;

   always_comb begin
      wmask = '0;
      for (int i = 0; i < DBITS; i++) begin
         wmask[i] = be_i[i/8];
      end
   end

   assign wdata = (mem[waddr_i] & ~wmask) | (din_i & wmask);

   // No hard macros are mapped yet; every target uses the behavioural array.
   if (TECHNOLOGY == "GENERIC") begin : g_generic
      always_ff @(posedge clk_i) begin
         if (we_i) mem[waddr_i] <= wdata;
         if (!rst_ni) dout_o <= '0;
         else if (re_i) dout_o <= (we_i && (waddr_i == raddr_i)) ? wdata : mem[raddr_i];
      end
   end else begin : g_fallback
      always_ff @(posedge clk_i) begin
         if (we_i) mem[waddr_i] <= wdata;
         if (!rst_ni) dout_o <= '0;
         else if (re_i) dout_o <= (we_i && (waddr_i == raddr_i)) ? wdata : mem[raddr_i];
      end
   end

endmodule

// File: rtl/rl_fifo_1r1w.sv
// First-word-fall-through FIFO on top of rl_ram_1r1w. A 2-entry prefetch
// buffer hides the RAM read latency so one push and one pop per cycle are
// sustained. Capacity is 2**ABITS RAM words plus the 2 buffer entries.
//   clk_i    clock
//   rst_ni   synchronous active-low reset
//   flush_i  synchronous clear, drops any read in flight
//   push_i   write request, accepted when full_o=0
//   din_i    write data
//   full_o   no push accepted this cycle
//   pop_i    consume head word, accepted when empty_o=0
//   dout_o   head word; holds last head value while empty
//   empty_o  no head word available
//   count_o  words held (RAM + in-flight read + buffer)
module rl_fifo_1r1w
   import rl_fifo_1r1w_pkg::*;
#(
   parameter int    ABITS      = 10,
   parameter int    DBITS      = 32,
   parameter string TECHNOLOGY = "GENERIC"
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [DBITS-1:0] din_i,
   output logic             full_o,
   input  logic             pop_i,
   output logic [DBITS-1:0] dout_o,
   output logic             empty_o,
   output logic [ABITS+1:0] count_o
);

   localparam int             MW  = ABITS + 1;
   localparam int             CW  = ABITS + 2;
   localparam logic [CW-1:0]  CAP = CW'(fifo_cap(ABITS));

   logic [ABITS-1:0] wptr_q, rptr_q;
   logic [MW-1:0]    mem_count_q;
   logic             rd_pending_q;
   logic [DBITS-1:0] buf_q [BUF_DEPTH];
   logic             head_q, tail_q;
   logic [1:0]       buf_count_q;
   logic [DBITS-1:0] last_q;
   logic [DBITS-1:0] ram_dout;
   logic             push_acc, pop_acc, rd_issue;

   assign count_o = CW'(mem_count_q) + CW'(rd_pending_q) + CW'(buf_count_q);
   assign full_o  = (count_o == CAP);
   assign empty_o = (buf_count_q == 2'd0);
   assign dout_o  = empty_o ? last_q : buf_q[head_q];

   assign push_acc = push_i & ~full_o;
   assign pop_acc  = pop_i & ~empty_o;

   // Fetch the next RAM word only if it will still have a buffer slot when
   // it lands, counting the read already in flight and this cycle's pop.
   assign rd_issue = (mem_count_q != '0) &&
                     (({1'b0, buf_count_q} + {2'b00, rd_pending_q}) < (3'd2 + {2'b00, pop_acc}));

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         mem_count_q  <= '0;
         rd_pending_q <= 1'b0;
         head_q       <= 1'b0;
         tail_q       <= 1'b0;
         buf_count_q  <= '0;
         last_q       <= '0;
      end else begin
         if (push_acc) wptr_q <= wptr_q + ABITS'(1);
         if (rd_issue) rptr_q <= rptr_q + ABITS'(1);
         mem_count_q  <= mem_count_q + MW'(push_acc) - MW'(rd_issue);
         rd_pending_q <= rd_issue;
         if (rd_pending_q) tail_q <= ~tail_q;
         if (pop_acc) head_q <= ~head_q;
         buf_count_q  <= buf_count_q + 2'(rd_pending_q) - 2'(pop_acc);
         last_q       <= dout_o;
      end
   end

   // Buffer storage needs no reset: dout_o is taken from last_q while empty.
   always_ff @(posedge clk_i) begin
      if (rd_pending_q) buf_q[tail_q] <= ram_dout;
   end

   rl_ram_1r1w #(
      .ABITS      (ABITS),
      .DBITS      (DBITS),
      .TECHNOLOGY (TECHNOLOGY)
   ) u_ram (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (push_acc),
      .waddr_i (wptr_q),
      .din_i   (din_i),
      .be_i    ('1),
      .re_i    (rd_issue),
      .raddr_i (rptr_q),
      .dout_o  (ram_dout)
   );

   a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (count_o <= CAP) && (buf_count_q <= 2'd2) && (mem_count_q <= MW'(2**ABITS)));

endmodule

// File: tb/tb_rl_fifo_1r1w.sv
module tb_rl_fifo_1r1w;

   localparam int ABITS = 2;
   localparam int DBITS = 8;
   localparam int CAP   = 6;

   logic             clk = 1'b0;
   logic             rst_n, flush, push, pop;
   logic [DBITS-1:0] din;
   logic             full, empty;
   logic [DBITS-1:0] dout;
   logic [ABITS+1:0] count;

   always #5 clk = ~clk;

   rl_fifo_1r1w #(.ABITS(ABITS), .DBITS(DBITS), .TECHNOLOGY("GENERIC")) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .flush_i (flush),
      .push_i  (push),
      .din_i   (din),
      .full_o  (full),
      .pop_i   (pop),
      .dout_o  (dout),
      .empty_o (empty),
      .count_o (count)
   );

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   // Reference model: ordered queue of held words. vis = words visible at the
   // head (already prefetched), fly = word in the RAM read pipeline.
   logic [DBITS-1:0] mq[$];
   int               vis = 0;
   int               fly = 0;
   logic [DBITS-1:0] e_dout = '0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                    name, act, act, exp, exp, $time);
   endtask

   task automatic model_reset();
      mq.delete();
      vis    = 0;
      fly    = 0;
      e_dout = '0;
   endtask

   task automatic model_update(input bit pu, input logic [DBITS-1:0] d,
                               input bit po, input bit fl);
      bit               pop_ok, push_ok, fetch;
      int               in_ram;
      logic [DBITS-1:0] prev;
      if (fl) begin
         model_reset();
         return;
      end
      prev    = e_dout;
      pop_ok  = po && (vis > 0);
      push_ok = pu && (mq.size() < CAP);
      in_ram  = mq.size() - vis - fly;
      fetch   = (in_ram > 0) && ((vis + fly - int'(pop_ok)) < 2);
      vis     = vis - int'(pop_ok) + fly;
      fly     = int'(fetch);
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back(d);
      e_dout  = (vis > 0) ? mq[0] : prev;
   endtask

   task automatic step(input bit pu, input logic [DBITS-1:0] d,
                       input bit po, input bit fl);
      push  = pu;
      din   = d;
      pop   = po;
      flush = fl;
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_update(pu, d, po, fl);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("empty_o", int'(empty), int'(vis == 0));
         check("full_o",  int'(full),  int'(mq.size() == CAP));
         check("count_o", int'(count), mq.size());
         check("dout_o",  int'(dout),  int'(e_dout));
      end
   end

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
      din   = '0;
      @(negedge clk);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // reset state
      check("rst_empty", int'(empty), 1);
      check("rst_full",  int'(full),  0);
      check("rst_count", int'(count), 0);
      check("rst_dout",  int'(dout),  0);

      // single word: visible after the second edge
      step(1, 8'hA5, 0, 0);
      check("single_e0_empty", int'(empty), 1);
      step(0, 0, 0, 0);
      check("single_e1_empty", int'(empty), 1);
      step(0, 0, 0, 0);
      check("single_e2_empty", int'(empty), 0);
      check("single_e2_dout",  int'(dout),  8'hA5);
      step(0, 0, 1, 0);
      check("single_pop_empty", int'(empty), 1);
      check("single_pop_count", int'(count), 0);

      // fill to capacity, overflow push dropped, drain in order
      for (int i = 1; i <= 6; i++) step(1, 8'(i), 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("fill_full",  int'(full),  1);
      check("fill_count", int'(count), 6);
      step(1, 8'h07, 0, 0);
      check("fill_drop_count", int'(count), 6);
      for (int i = 1; i <= 6; i++) begin
         check("fill_order", int'(dout), i);
         step(0, 0, 1, 0);
      end
      check("fill_drained_empty", int'(empty), 1);

      // full with push and pop together: pop wins, push dropped
      for (int i = 1; i <= 6; i++) step(1, 8'(8'h10 + i), 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 8'h77, 1, 0);
      check("fullpp_count", int'(count), 5);
      check("fullpp_full",  int'(full),  0);
      check("fullpp_head",  int'(dout),  8'h12);
      for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
      check("fullpp_drain_count", int'(count), 0);
      check("fullpp_last_dout",   int'(dout),  8'h16);

      // flush with a read in flight and three words held
      step(1, 8'h31, 0, 0);
      step(1, 8'h32, 0, 0);
      step(1, 8'h33, 0, 0);
      check("flush_pre_count", int'(count), 3);
      step(0, 0, 0, 1);
      check("flush_count", int'(count), 0);
      check("flush_empty", int'(empty), 1);
      check("flush_dout",  int'(dout),  0);
      step(1, 8'h3C, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("flush_after_empty", int'(empty), 0);
      check("flush_after_dout",  int'(dout),  8'h3C);
      step(0, 0, 1, 0);
      check("flush_after_pop_count", int'(count), 0);

      // streaming: push and pop every cycle, 64 words through a 4-deep RAM
      for (int k = 0; k < 64; k++) begin
         if (k >= 3) begin
            check("stream_no_bubble", int'(empty), 0);
            check("stream_order",     int'(dout),  (k - 3) & 8'hFF);
         end
         step(1, 8'(k), 1, 0);
         if (k >= 2) check("stream_count", int'(count), 3);
      end
      for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
      check("stream_drain_count", int'(count), 0);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
              $urandom_range(0, 199) < 3);
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
